// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master subsystem.
package spi_pkg;

  localparam int NUM_SLAVES = 2;
  localparam int DATA_W     = 8;
  localparam int CNT_W      = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT_HI,
    ST_SHIFT_LO,
    ST_HOLD
  } spi_state_e;

endpackage

// File: rtl/spi_master_if.sv
// SPI bus between one master and the slaves; ss_n is active-low, one bit per slave.
interface SPIbus import spi_pkg::*; ();

  logic                  sclk;
  logic                  mosi;
  logic                  miso;
  logic [NUM_SLAVES-1:0] ss_n;

  modport Master (output sclk, output mosi, output ss_n, input miso);
  modport Slave  (input sclk, input mosi, input ss_n, output miso);

endinterface

// File: rtl/spi_master_clk_div.sv
// Half-period tick generator: Tick_o is high on the last cycle of every CLK_DIV-cycle phase.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic Clk_i,
  input  logic Rst_ni,
  input  logic Clr_i,
  output logic Tick_o
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign Tick_o = (cnt_q == LAST);

  // Next count: wrap on tick, restart when a transfer is accepted.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (Clr_i || Tick_o) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge Clk_i) begin
    if (!Rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master.sv
// Single-byte SPI mode-0 master: MSB-first shift out on MOSI, capture on MISO.
module spi_master import spi_pkg::*; #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic                  Clk_i,
  input  logic                  Rst_ni,
  input  logic [DATA_W-1:0]     Buf_i,
  input  logic [NUM_SLAVES-1:0] ss_i,
  input  logic                  Strobe_i,
  SPIbus.Master                 Spim,
  output logic                  Busy_o,
  output logic [DATA_W-1:0]     RxData_o,
  output logic                  RxValid_o
);

  spi_state_e            state_q;
  logic [DATA_W-1:0]     tx_q;
  logic [DATA_W-1:0]     rx_q;
  logic [DATA_W-1:0]     rx_data_q;
  logic [NUM_SLAVES-1:0] ss_n_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic                  sclk_q;
  logic                  busy_q;
  logic                  rx_valid_q;
  logic                  tick;
  logic                  accept;

  assign accept = (state_q == ST_IDLE) && Strobe_i && (ss_i != '0);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .Clk_i  (Clk_i),
    .Rst_ni (Rst_ni),
    .Clr_i  (accept),
    .Tick_o (tick)
  );

  // Transfer FSM; every bus-facing output is a register updated here.
  always_ff @(posedge Clk_i) begin
    if (!Rst_ni) begin
      state_q    <= ST_IDLE;
      tx_q       <= '0;
      rx_q       <= '0;
      rx_data_q  <= '0;
      ss_n_q     <= '1;
      bit_cnt_q  <= '0;
      sclk_q     <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            tx_q      <= Buf_i;
            ss_n_q    <= ~ss_i;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tick) begin
            sclk_q    <= 1'b1;
            rx_q      <= {rx_q[DATA_W-2:0], Spim.miso};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            state_q   <= ST_SHIFT_HI;
          end
        end
        ST_SHIFT_HI: begin
          if (tick) begin
            sclk_q  <= 1'b0;
            tx_q    <= {tx_q[DATA_W-2:0], 1'b0};
            state_q <= ST_SHIFT_LO;
          end
        end
        ST_SHIFT_LO: begin
          if (tick) begin
            if (bit_cnt_q == CNT_W'(DATA_W)) begin
              state_q <= ST_HOLD;
            end else begin
              sclk_q    <= 1'b1;
              rx_q      <= {rx_q[DATA_W-2:0], Spim.miso};
              bit_cnt_q <= bit_cnt_q + 1'b1;
              state_q   <= ST_SHIFT_HI;
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            ss_n_q     <= '1;
            rx_data_q  <= rx_q;
            rx_valid_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // MOSI is the TX register MSB; it only moves on the SHIFT_LO entry shift.
  assign Spim.mosi = tx_q[DATA_W-1];
  assign Spim.sclk = sclk_q;
  assign Spim.ss_n = ss_n_q;
  assign Busy_o    = busy_q;
  assign RxData_o  = rx_data_q;
  assign RxValid_o = rx_valid_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: two instances (CLK_DIV=1 and CLK_DIV=3).
module tb_spi_master;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    logic [1:0] ss;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] buf_s   [2];
  logic [1:0] ss_s    [2];
  logic       strobe_s[2];
  logic       loop_s  [2];
  logic [7:0] sbyte_s [2];

  logic       busy_w[2];
  logic       rxv_w [2];
  logic       sclk_w[2];
  logic       mosi_w[2];
  logic [1:0] ssn_w [2];
  logic [7:0] rxd_w [2];
  int         rises_w[2];

  exp_t q0[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  for (genvar g = 0; g < 2; g++) begin : gm
    localparam int H = (g == 0) ? 1 : 3;

    SPIbus sb ();

    spi_master #(
      .CLK_DIV (H)
    ) u_dut (
      .Clk_i     (clk),
      .Rst_ni    (rst_n),
      .Buf_i     (buf_s[g]),
      .ss_i      (ss_s[g]),
      .Strobe_i  (strobe_s[g]),
      .Spim      (sb),
      .Busy_o    (busy_w[g]),
      .RxData_o  (rxd_w[g]),
      .RxValid_o (rxv_w[g])
    );

    // Slave model: presents its byte MSB-first, advancing after each sclk fall.
    int         fall_cnt = 0;
    logic [7:0] slave_sh;
    assign slave_sh = sbyte_s[g] << fall_cnt;
    assign sb.miso  = loop_s[g] ? sb.mosi : slave_sh[7];

    assign sclk_w[g] = sb.sclk;
    assign mosi_w[g] = sb.mosi;
    assign ssn_w[g]  = sb.ss_n;

    bit         active = 1'b0;
    bit         tbad   = 1'b0;
    logic       sclk_p = 1'b0;
    logic       mosi_p = 1'b0;
    logic       rxv_p  = 1'b0;
    int         off    = 0;
    int         rises  = 0;
    int         low_len = 0;
    logic [7:0] cap    = '0;
    logic [1:0] seen_ss = 2'b11;

    assign rises_w[g] = rises;

    // Bus monitor and scoreboard checker, sampled on the falling clock edge.
    always @(negedge clk) begin : mon
      exp_t       e;
      int         pend;
      logic [1:0] ssn_exp;
      if (sb.ss_n != 2'b11 && sb.ss_n !== 2'bxx) begin
        if (!active) begin
          active  = 1'b1;
          off     = 0;
          seen_ss = sb.ss_n;
          rises   = 0;
          cap     = '0;
          tbad    = 1'b0;
          mosi_p  = sb.mosi;
        end else begin
          off++;
        end
        if (sb.ss_n != seen_ss) tbad = 1'b1;
        if (sb.sclk && !sclk_p) begin
          if (off != H + 2 * H * rises) tbad = 1'b1;
          cap = {cap[6:0], sb.mosi};
          rises++;
        end
        if (!sb.sclk && sclk_p) begin
          if (off != 2 * H * rises) tbad = 1'b1;
          fall_cnt++;
        end
        if (sb.mosi != mosi_p && !(sclk_p && !sb.sclk)) tbad = 1'b1;
      end else begin
        if (active) begin
          active  = 1'b0;
          low_len = off + 1;
        end
        fall_cnt = 0;
      end

      if (rxv_w[g] === 1'b1) begin
        pend = qsize(g);
        chk($sformatf("d%0d_valid_expected", g), pend > 0, 1);
        chk($sformatf("d%0d_valid_one_cycle", g), rxv_p, 0);
        if (pend > 0 && !rxv_p) begin
          if (g == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          ssn_exp = ~e.ss;
          chk($sformatf("d%0d_rx_data", g), rxd_w[g], e.rx);
          chk($sformatf("d%0d_mosi_bits", g), cap, e.tx);
          chk($sformatf("d%0d_ss_n_during", g), seen_ss, ssn_exp);
          chk($sformatf("d%0d_ss_low_cycles", g), low_len, 18 * H);
          chk($sformatf("d%0d_sclk_rises", g), rises, 8);
          chk($sformatf("d%0d_phase_timing", g), tbad, 0);
          chk($sformatf("d%0d_ss_n_on_valid", g), sb.ss_n, 2'b11);
          chk($sformatf("d%0d_busy_on_valid", g), busy_w[g], 0);
        end
      end

      sclk_p = sb.sclk;
      mosi_p = sb.mosi;
      rxv_p  = rxv_w[g];
    end
  end

  task automatic xfer(input int d, input logic [7:0] b, input logic [1:0] s,
                      input bit lp, input logic [7:0] sbyte);
    exp_t e;
    loop_s[d]   = lp;
    sbyte_s[d]  = sbyte;
    buf_s[d]    = b;
    ss_s[d]     = s;
    strobe_s[d] = 1'b1;
    if (s != 2'b00) begin
      e.tx = b;
      e.rx = lp ? b : sbyte;
      e.ss = s;
      push(d, e);
    end
    @(negedge clk);
    strobe_s[d] = 1'b0;
    buf_s[d]    = 8'($urandom);
    ss_s[d]     = 2'($urandom);
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while ((busy_w[d] !== 1'b0 || qsize(d) != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("d%0d_done_in_time", d), n < 400, 1);
  endtask

  task automatic chk_reset_outputs(input int d, input string tag);
    chk($sformatf("d%0d_%s_ss_n", d, tag), ssn_w[d], 2'b11);
    chk($sformatf("d%0d_%s_sclk", d, tag), sclk_w[d], 0);
    chk($sformatf("d%0d_%s_mosi", d, tag), mosi_w[d], 0);
    chk($sformatf("d%0d_%s_busy", d, tag), busy_w[d], 0);
    chk($sformatf("d%0d_%s_rxdata", d, tag), rxd_w[d], 8'h00);
    chk($sformatf("d%0d_%s_rxvalid", d, tag), rxv_w[d], 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    strobe_s = '{1'b0, 1'b0};
    buf_s    = '{8'h00, 8'h00};
    ss_s     = '{2'b00, 2'b00};
    loop_s   = '{1'b1, 1'b1};
    sbyte_s  = '{8'h00, 8'h00};

    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs(0, "reset");
    chk_reset_outputs(1, "reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic loopback transfer to slave 1.
    xfer(0, 8'hAA, 2'b10, 1'b1, 8'h00);
    wait_idle(0);

    // Receive path independent of transmit data.
    xfer(0, 8'h00, 2'b01, 1'b0, 8'h3C);
    wait_idle(0);

    // Strobe with empty select mask is ignored.
    buf_s[0] = 8'h55; ss_s[0] = 2'b00; strobe_s[0] = 1'b1;
    @(negedge clk);
    strobe_s[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("d0_nosel_busy", busy_w[0], 0);
      chk("d0_nosel_ss_n", ssn_w[0], 2'b11);
      @(negedge clk);
    end

    // Strobe during a transfer is ignored.
    xfer(0, 8'h5A, 2'b01, 1'b1, 8'h00);
    repeat (6) @(negedge clk);
    buf_s[0] = 8'hFF; ss_s[0] = 2'b11; strobe_s[0] = 1'b1;
    @(negedge clk);
    strobe_s[0] = 1'b0;
    wait_idle(0);
    repeat (25) @(negedge clk);
    chk("d0_no_second_xfer_busy", busy_w[0], 0);

    // Reset after the third sclk rise aborts the transfer.
    xfer(0, 8'hC3, 2'b10, 1'b1, 8'h00);
    @(negedge clk);
    n = 0;
    while (rises_w[0] < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("d0_third_rise_seen", rises_w[0], 3);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs(0, "midreset");
    q0.delete();
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("d0_after_abort_idle", busy_w[0], 0);

    // Randomized transfers, back-to-back.
    for (int i = 0; i < 12; i++) begin
      xfer(0, 8'($urandom), 2'($urandom_range(1, 3)), 1'($urandom), 8'($urandom));
      wait_idle(0);
    end

    // Slow clock divider with broadcast select.
    xfer(1, 8'h81, 2'b11, 1'b1, 8'h00);
    wait_idle(1);
    for (int i = 0; i < 4; i++) begin
      xfer(1, 8'($urandom), 2'($urandom_range(1, 3)), 1'($urandom), 8'($urandom));
      wait_idle(1);
    end

    repeat (5) @(negedge clk);
    chk("d0_queue_drained", q0.size(), 0);
    chk("d1_queue_drained", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
